// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deframer
// Description : 8N1 UART receive deframer. Synchronises the serial line,
//               finds the start bit, samples eight data bits LSB first and
//               checks the stop bit. A good frame updates data and pulses
//               data_valid. A low stop bit pulses frame_err and parks the
//               FSM in BREAK until the line returns high.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               rx         - asynchronous serial input, idle high
//               data       - last correctly framed byte
//               data_valid - one-cycle pulse, data is new
//               frame_err  - one-cycle pulse, stop bit sampled low
//               busy       - FSM is not idle
// Parameters  : CLKS_PER_BIT - clk cycles per bit, 8..4095
// Build macro : UART_RX_MAJORITY_EN - 2-of-3 majority sampling around the
//               bit centre instead of a single mid-bit sample
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 833
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // The majority decision is taken one cycle after the bit centre. Only the
    // start bit needs the extra cycle; every later bit keeps the full bit
    // period between decisions, so the whole frame shifts by one cycle.
`ifdef UART_RX_MAJORITY_EN
    localparam int c_START_TC_INT = CLKS_PER_BIT / 2;
`else
    localparam int c_START_TC_INT = CLKS_PER_BIT / 2 - 1;
`endif
    localparam logic [c_CW-1:0] c_START_TC = c_CW'(c_START_TC_INT);
    localparam logic [c_CW-1:0] c_BIT_TC   = c_CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    logic            w_sample;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic [7:0]      r_data;
    logic [7:0]      w_data_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_err;
    logic            w_err_nxt;

    // Two-flop synchroniser; flops reset high so reset never looks like a
    // falling edge on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] holds rx_s at the bit centre, r_hist[1] the cycle before it,
    // when the counter reaches the decision point one cycle past the centre.
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) |
                      (r_hist[0] & w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_START: begin
                if (r_cnt == c_START_TC) begin
                    w_cnt_nxt = '0;
                    if (!w_sample) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == c_BIT_TC) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_sample, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == c_BIT_TC) begin
                    w_cnt_nxt = '0;
                    if (w_sample) begin
                        // Leaving at mid-stop lets a back-to-back start bit
                        // be caught from IDLE.
                        w_state_nxt = S_IDLE;
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_BREAK;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
